// File: rtl/platform_scroll_sched.sv
// rtl/platform_scroll_sched.sv - frame divider, scroll burst sequencer and platform recycle scan
// The recycle scan is built only when PLATFORM_RECYCLE_EN is defined.
module platform_scroll_sched #(
  parameter int CLK          = 50000000,
  parameter int FPS          = 50,
  parameter int SLOTS        = 93,
  parameter int STEP         = 10,
  parameter int SCROLL_STEPS = 3,
  parameter int LAND_LIMIT   = 520,
  parameter int SCREEN_H     = 600,
  parameter int WRAP         = 930,
  parameter int DENSITY      = 6,
  localparam int IW          = $clog2(SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 land,
  input  logic [9:0]           land_y,
  input  logic [15:0]          rnd,
  input  logic signed [10:0]   slot_y,
  output logic                 frame_tick,
  output logic                 scroll_pulse,
  output logic [1:0]           scroll_count,
  output logic [IW-1:0]        rd_idx,
  output logic                 wr_en,
  output logic [IW-1:0]        wr_idx,
  output logic signed [10:0]   wr_y,
  output logic                 wr_active,
  output logic                 busy
);

  localparam int FRAME_CYCLES = CLK / FPS;
  localparam int CW = $clog2(FRAME_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SCROLL, SCAN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] frame_cnt;
  logic          tick_now;
  logic          land_ok;
  logic          take;
  logic          pend, pend_next;
  logic          pulse_next;
  logic [1:0]    count_next;
  logic          scan_last;
  logic          unused_cfg;

  assign unused_cfg = (STEP != 0);

  // Pulse/count/tick are all decided on the last divider cycle so they appear together.
  assign tick_now = (frame_cnt == CW'(FRAME_CYCLES - 1));
  assign land_ok  = land && ({22'd0, land_y} < 32'(LAND_LIMIT));
  assign take     = pend || land_ok;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pulse_next = 1'b0;
    count_next = scroll_count;
    pend_next  = take;
    case (state)
      IDLE: begin
        if (tick_now && take) begin
          pulse_next = 1'b1;
          count_next = 2'd1;
          pend_next  = 1'b0;
          state_next = SCROLL;
        end
      end
      SCROLL: begin
        if (tick_now) begin
          if (take) begin
            pulse_next = 1'b1;
            count_next = 2'd1;
            pend_next  = 1'b0;
          end else if (scroll_count == 2'(SCROLL_STEPS)) begin
            count_next = 2'd0;
`ifdef PLATFORM_RECYCLE_EN
            state_next = SCAN;
`else
            state_next = IDLE;
`endif
          end else begin
            pulse_next = 1'b1;
            count_next = scroll_count + 2'd1;
          end
        end
      end
      SCAN: begin
        if (scan_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt    <= '0;
      frame_tick   <= 1'b0;
      scroll_pulse <= 1'b0;
      scroll_count <= 2'd0;
      pend         <= 1'b0;
    end else begin
      frame_cnt    <= tick_now ? '0 : frame_cnt + CW'(1);
      frame_tick   <= tick_now;
      scroll_pulse <= pulse_next;
      scroll_count <= count_next;
      pend         <= pend_next;
    end
  end

`ifdef PLATFORM_RECYCLE_EN
  localparam logic signed [10:0] SCREEN_Y = 11'(SCREEN_H);
  localparam logic signed [10:0] WRAP_Y   = 11'(WRAP);

  logic [IW-1:0] scan_idx;
  logic [1:0]    col;
  logic          row_any;
  logic          row_prev;
  logic          scanning;
  logic          recycle;
  logic          act;
  logic          unused_rnd;

  assign unused_rnd = ^rnd[15:4];
  assign rd_idx     = scan_idx;
  assign scanning   = (state == SCAN) && !scan_last;
  assign recycle    = scanning && (slot_y >= SCREEN_Y);
  // Last slot of a row with no active recycle yet is forced active so every row stays reachable.
  assign row_prev   = (col == 2'd0) ? 1'b0 : row_any;
  assign act        = ({28'd0, rnd[3:0]} < 32'(DENSITY)) || ((col == 2'd2) && !row_prev);

  always_ff @(posedge clk) begin
    if (rst || state != SCAN) begin
      scan_idx  <= '0;
      scan_last <= 1'b0;
      col       <= 2'd0;
      row_any   <= 1'b0;
      wr_en     <= 1'b0;
      wr_idx    <= '0;
      wr_y      <= '0;
      wr_active <= 1'b0;
    end else begin
      wr_en     <= recycle;
      wr_idx    <= recycle ? scan_idx : '0;
      wr_y      <= recycle ? (slot_y - WRAP_Y) : '0;
      wr_active <= recycle && act;
      if (!scan_last) begin
        row_any <= row_prev || (recycle && act);
        col     <= (col == 2'd2) ? 2'd0 : col + 2'd1;
        if (scan_idx == IW'(SLOTS - 1)) begin
          scan_last <= 1'b1;
          scan_idx  <= '0;
        end else begin
          scan_idx <= scan_idx + IW'(1);
        end
      end
    end
  end
`else
  logic unused_in;

  assign unused_in = ^{slot_y, rnd};
  assign scan_last = 1'b1;
  assign rd_idx    = '0;
  assign wr_en     = 1'b0;
  assign wr_idx    = '0;
  assign wr_y      = '0;
  assign wr_active = 1'b0;
`endif

endmodule
